shadowmask_cmd_seq: RTL and testbench
=====================================

# shadowmask_cmd_seq

Command sequencer that owns the configuration port of the shadow-mask video stage. Host software stages a complete mask description, up to 128 16-bit command words, into a local buffer. On commit, the block replays the buffer into the mask stage as a back-to-back `cmd_wr`/`cmd_out` burst aligned to the start of vertical blank, so a mask is never half-applied on screen. It also owns the control word (rotate/2x/enable), shadowing it so a global mask-off override can be applied or released at any time without the host resending the mask.

## Interface
Parameters:
- `DEPTH_LOG2`, 7: staging buffer depth is 2^DEPTH_LOG2 words.
- `SYNC_VB`, 1: 1 means the burst waits for a vblank rising edge; 0 means the burst starts immediately.

Ports:
- `clk_sys`  in  1: system clock; all logic is on this clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `stg_wr`  in  1: staging write strobe.
- `stg_addr`  in  DEPTH_LOG2: staging write address.
- `stg_data`  in  16: staged command word, in the mask-stage command format.
- `commit_req`  in  1: single-cycle request to apply the staged words.
- `commit_len`  in  DEPTH_LOG2+1: number of staged words to send (1..2^DEPTH_LOG2); sampled with `commit_req`.
- `force_off`  in  1: level input; when high, the emitted enable bit is 0.
- `vblank`  in  1: vertical blank from the video clock domain; asynchronous to `clk_sys`.
- `cmd_wr`  out  1: command strobe to the mask stage.
- `cmd_out`  out  16: command word to the mask stage.
- `busy`  out  1: a sequence is in progress.
- `done`  out  1: one-cycle pulse when a sequence completes.
- `err`  out  1: one-cycle pulse when a request or write is rejected.

## Operation
- Reset values:
  - Outputs `cmd_wr`, `cmd_out`, `busy`, `done` and `err` are all 0.
  - The state machine is in IDLE.
  - The shadow control register `{rot,x2,en}` is 3'b000.
  - The previous-`force_off` register is 0.
  - Buffer contents are undefined.
- Staging writes:
  - Accepted only in IDLE.
  - `stg_wr` outside IDLE drops the write and pulses `err`.
- `vblank` synchronization: passes through a 2-FF synchronizer, then an edge detector; `vb_rise` is 1 for one cycle.
- State machine:
  - IDLE:
    - `commit_req` with `commit_len` in range: latch the length and go to WAIT_VB (SYNC_VB=1) or SEND (SYNC_VB=0).
    - `commit_len` of 0 or greater than 2^DEPTH_LOG2: pulse `err` and stay in IDLE.
    - A `force_off` edge with no commit in the same cycle: go to CTL.
  - WAIT_VB: wait for `vb_rise`, then go to SEND. There is no timeout.
  - SEND:
    - Read staged words at addresses 0..len-1, one per cycle.
    - A word with opcode [15:13]=3'b000 is not emitted; its bits [2:0] load the shadow register, and that output slot has `cmd_wr`=0.
    - Every other opcode, including unused ones, is forwarded unchanged.
    - After the last read, go to CTL.
  - CTL: emit `{3'b000, 10'b0, rot, x2, en & ~force_off}` for one cycle, then go to FIN.
  - FIN: pulse `done`, drop `busy`, and return to IDLE.
- `commit_req` outside IDLE is ignored and pulses `err`.
- A `force_off` edge outside IDLE needs no separate action; the CTL word at the end of the sequence reflects the `force_off` level sampled in CTL.
- A `force_off` edge is detected against a register that updates every cycle.
- A standalone CTL (from IDLE) does not pulse `done`.
- Reset asserted mid-sequence aborts immediately: outputs return to reset values, the shadow register clears, and no further words are emitted. The mask stage keeps whatever it already received.

## Timing
- `busy` rises the cycle after an accepted `commit_req`.
- With SYNC_VB=1, `vb_rise` occurs 2–3 cycles after the raw `vblank` rising edge.
- The first SEND output slot comes 2 cycles after entry to SEND: one cycle of buffer read latency plus the output register.
- Slots are back-to-back. A len-N sequence occupies N SEND slots, then 1 CTL slot.
- `done` occurs 1 cycle after the CTL `cmd_wr`; `busy` falls in the same cycle as `done`.
- A standalone CTL `cmd_wr` occurs 2 cycles after the `force_off` edge.
- `cmd_out` holds its last value when `cmd_wr` is 0.

## Structure
- Package `shadowmask_pkg` holds:
  - Opcode constants: `OP_CTL`=0, `OP_VMAX`=1, `OP_HMAX`=2, `OP_LUT`=3, `OP_ON`=4, `OP_OFF`=5.
  - A state enum {IDLE, WAIT_VB, SEND, CTL, FIN}.
  - A command-word pack function for the control word.
- Sub-module `shadowmask_stage_ram`: simple dual-port 2^DEPTH_LOG2×16 buffer with registered read; writes come from host staging, reads from the sequencer.

## Test plan
- Stage 3 words 0x2005, 0x4007, 0x6123 at addresses 0–2; `commit_len`=3; pulse `vblank` → exactly 3 data slots followed by control word 0x0000, `done` one cycle later, `busy` high throughout.
- Stage 0x2003, 0x0005, 0x4006 (len 3); `force_off`=0 → 0x2003 emitted, a bubble slot, 0x4006 emitted, then control word 0x0005.
- Repeat the previous scenario, then raise `force_off` in IDLE → single `cmd_wr` of 0x0004 two cycles later with no `done`; drop `force_off` → 0x0005.
- `commit_len`=0 → `err` pulse, `busy` stays 0. `commit_req` while in WAIT_VB → `err` pulse, sequence unaffected. `stg_wr` while busy → `err` pulse, and the buffer word is unchanged on the next commit.
- `commit_len`=128 with SYNC_VB=0 → 128 consecutive slots starting 2 cycles after commit; address 127 is sent and the address counter does not wrap.
- Assert `reset_n` low during SEND word 10 of 20 → `cmd_wr`=0 immediately and no further words; after release, the first commit replays from word 0.

Source files
------------

// File: rtl/shadowmask_pkg.sv
// Shared opcodes, sequencer states and the control-word packer for the
// shadow-mask command sequencer.
package shadowmask_pkg;

  localparam logic [2:0] OP_CTL  = 3'd0;
  localparam logic [2:0] OP_VMAX = 3'd1;
  localparam logic [2:0] OP_HMAX = 3'd2;
  localparam logic [2:0] OP_LUT  = 3'd3;
  localparam logic [2:0] OP_ON   = 3'd4;
  localparam logic [2:0] OP_OFF  = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VB = 3'd1,
    SEND    = 3'd2,
    CTL     = 3'd3,
    FIN     = 3'd4
  } state_t;

  function automatic logic [15:0] pack_ctl(input logic rot, input logic x2, input logic en);
    return {OP_CTL, 10'b00_0000_0000, rot, x2, en};
  endfunction

endpackage

// File: rtl/shadowmask_stage_ram.sv
// Staging buffer: host writes on one port, sequencer reads on the other
// with a one-cycle registered read.
module shadowmask_stage_ram #(
  parameter int DEPTH_LOG2 = 7
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [15:0]           wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [15:0]           rd_data
);

  localparam int DEPTH = 32'd1 << DEPTH_LOG2;

  logic [15:0] mem_r [0:DEPTH-1];
  logic [15:0] rd_data_r;

  // Host write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered sequencer read port
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/shadowmask_cmd_seq.sv
// Replays a staged mask description into the mask stage as one burst aligned
// to vblank, and keeps a shadow of the control word for the force-off override.
module shadowmask_cmd_seq
  import shadowmask_pkg::*;
#(
  parameter int DEPTH_LOG2 = 7,
  parameter int SYNC_VB    = 1
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  stg_wr,
  input  logic [DEPTH_LOG2-1:0] stg_addr,
  input  logic [15:0]           stg_data,
  input  logic                  commit_req,
  input  logic [DEPTH_LOG2:0]   commit_len,
  input  logic                  force_off,
  input  logic                  vblank,
  output logic                  cmd_wr,
  output logic [15:0]           cmd_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [DEPTH_LOG2:0] DEPTH_W = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE_W   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] ZERO_W  = {(DEPTH_LOG2+1){1'b0}};

  state_t              state_r, next_state_s;
  logic                seq_r, next_seq_s;
  logic [DEPTH_LOG2:0] len_r, len_nxt_s;
  logic [DEPTH_LOG2:0] cnt_r, cnt_nxt_s;
  logic [2:0]          shadow_r, shadow_nxt_s;
  logic                rd_vld_r, rd_en_s;
  logic [15:0]         rd_data_s;
  logic                ram_we_s;
  logic                vb_meta_r, vb_sync_r, vb_prev_r, vb_rise_s;
  logic                fo_prev_r, fo_edge_s;
  logic                len_ok_s, bad_len_s;
  logic                cmd_wr_s, done_s, err_s, busy_s;
  logic [15:0]         cmd_out_s;
  logic                cmd_wr_r, busy_r, done_r, err_r;
  logic [15:0]         cmd_out_r;

  shadowmask_stage_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk     (clk_sys),
    .wr_en   (ram_we_s),
    .wr_addr (stg_addr),
    .wr_data (stg_data),
    .rd_en   (rd_en_s),
    .rd_addr (cnt_r[DEPTH_LOG2-1:0]),
    .rd_data (rd_data_s)
  );

  assign vb_rise_s = vb_sync_r & ~vb_prev_r;
  assign fo_edge_s = force_off ^ fo_prev_r;
  assign len_ok_s  = (commit_len != ZERO_W) && (commit_len <= DEPTH_W);
  assign ram_we_s  = stg_wr && (state_r == IDLE);

  // Next-state, slot decode and pulse generation
  always_comb begin
    next_state_s = state_r;
    next_seq_s   = seq_r;
    len_nxt_s    = len_r;
    cnt_nxt_s    = cnt_r;
    shadow_nxt_s = shadow_r;
    rd_en_s      = 1'b0;
    cmd_wr_s     = 1'b0;
    cmd_out_s    = cmd_out_r;
    done_s       = 1'b0;
    bad_len_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (commit_req) begin
          if (len_ok_s) begin
            len_nxt_s    = commit_len;
            cnt_nxt_s    = ZERO_W;
            next_seq_s   = 1'b1;
            next_state_s = (SYNC_VB != 0) ? WAIT_VB : SEND;
          end else begin
            bad_len_s = 1'b1;
          end
        end else if (fo_edge_s) begin
          next_seq_s   = 1'b0;
          next_state_s = CTL;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT_VB: begin
        if (vb_rise_s) begin
          next_state_s = SEND;
        end else begin
          next_state_s = WAIT_VB;
        end
      end
      SEND: begin
        // One extra cycle after the last read lets the final word drain
        if (cnt_r < len_r) begin
          rd_en_s   = 1'b1;
          cnt_nxt_s = cnt_r + ONE_W;
        end else begin
          next_state_s = CTL;
        end
      end
      CTL: begin
        cmd_wr_s     = 1'b1;
        cmd_out_s    = pack_ctl(shadow_r[2], shadow_r[1], shadow_r[0] & ~force_off);
        next_state_s = seq_r ? FIN : IDLE;
      end
      FIN: begin
        done_s       = 1'b1;
        next_seq_s   = 1'b0;
        next_state_s = IDLE;
      end
      default: begin
        next_seq_s   = 1'b0;
        next_state_s = IDLE;
      end
    endcase
    // Control words are absorbed into the shadow and leave an empty slot
    if (rd_vld_r) begin
      if (rd_data_s[15:13] == OP_CTL) begin
        shadow_nxt_s = rd_data_s[2:0];
      end else begin
        cmd_wr_s  = 1'b1;
        cmd_out_s = rd_data_s;
      end
    end else begin
      shadow_nxt_s = shadow_nxt_s;
    end
  end

  assign err_s  = bad_len_s | ((state_r != IDLE) & (stg_wr | commit_req));
  assign busy_s = next_seq_s & (next_state_s != IDLE);

  // Sequencer state and registered outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      seq_r     <= 1'b0;
      len_r     <= ZERO_W;
      cnt_r     <= ZERO_W;
      shadow_r  <= 3'b000;
      rd_vld_r  <= 1'b0;
      vb_meta_r <= 1'b0;
      vb_sync_r <= 1'b0;
      vb_prev_r <= 1'b0;
      fo_prev_r <= 1'b0;
      cmd_wr_r  <= 1'b0;
      cmd_out_r <= 16'h0000;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      seq_r     <= next_seq_s;
      len_r     <= len_nxt_s;
      cnt_r     <= cnt_nxt_s;
      shadow_r  <= shadow_nxt_s;
      rd_vld_r  <= rd_en_s;
      vb_meta_r <= vblank;
      vb_sync_r <= vb_meta_r;
      vb_prev_r <= vb_sync_r;
      fo_prev_r <= force_off;
      cmd_wr_r  <= cmd_wr_s;
      cmd_out_r <= cmd_out_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      err_r     <= err_s;
    end
  end

  assign cmd_wr  = cmd_wr_r;
  assign cmd_out = cmd_out_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign err     = err_r;

endmodule

// File: tb/tb_shadowmask_cmd_seq.sv
// Directed bench for shadowmask_cmd_seq: one vblank-synced instance and one
// immediate-start instance sharing the staging and control inputs.
module tb_shadowmask_cmd_seq;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        stg_wr = 1'b0;
  logic [6:0]  stg_addr = 7'd0;
  logic [15:0] stg_data = 16'h0000;
  logic        commit_req = 1'b0;
  logic        commit_req0 = 1'b0;
  logic [7:0]  commit_len = 8'd0;
  logic        force_off = 1'b0;
  logic        vblank = 1'b0;

  logic        cmd_wr, busy, done, err;
  logic [15:0] cmd_out;
  logic        cmd_wr0, busy0, done0, err0;
  logic [15:0] cmd_out0;

  int          n_checks = 0;
  int          n_errors = 0;
  int          q_cyc[$];
  logic [15:0] q_word[$];
  int          q_done[$];
  bit          busy_log [0:255];

  always #5 clk_sys = ~clk_sys;

  shadowmask_cmd_seq #(.DEPTH_LOG2(7), .SYNC_VB(1)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .stg_wr(stg_wr), .stg_addr(stg_addr),
    .stg_data(stg_data), .commit_req(commit_req), .commit_len(commit_len),
    .force_off(force_off), .vblank(vblank), .cmd_wr(cmd_wr), .cmd_out(cmd_out),
    .busy(busy), .done(done), .err(err)
  );

  shadowmask_cmd_seq #(.DEPTH_LOG2(7), .SYNC_VB(0)) dut0 (
    .clk_sys(clk_sys), .reset_n(reset_n), .stg_wr(stg_wr), .stg_addr(stg_addr),
    .stg_data(stg_data), .commit_req(commit_req0), .commit_len(commit_len),
    .force_off(force_off), .vblank(vblank), .cmd_wr(cmd_wr0), .cmd_out(cmd_out0),
    .busy(busy0), .done(done0), .err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic stage(input logic [6:0] addr, input logic [15:0] data);
    stg_wr = 1'b1; stg_addr = addr; stg_data = data;
    step();
    stg_wr = 1'b0;
  endtask

  task automatic commit(input logic [7:0] len);
    commit_req = 1'b1; commit_len = len;
    step();
    commit_req = 1'b0;
  endtask

  task automatic vb_low();
    vblank = 1'b0;
    repeat (4) step();
  endtask

  task automatic capture(input int ncyc, input bit sel);
    q_cyc.delete(); q_word.delete(); q_done.delete();
    for (int i = 0; i < ncyc; i++) begin
      step();
      if (sel ? cmd_wr0 : cmd_wr) begin
        q_cyc.push_back(i);
        q_word.push_back(sel ? cmd_out0 : cmd_out);
      end
      if (sel ? done0 : done) q_done.push_back(i);
      busy_log[i] = sel ? busy0 : busy;
    end
  endtask

  task automatic chk_slot(input string tag, input int idx, input int exp_cyc, input logic [15:0] exp_word);
    if (idx < q_word.size()) begin
      chk({tag, "_cyc"}, q_cyc[idx], exp_cyc);
      chk({tag, "_word"}, {16'h0000, q_word[idx]}, {16'h0000, exp_word});
    end else begin
      chk({tag, "_missing"}, q_word.size(), idx + 1);
    end
  endtask

  task automatic chk_done(input string tag, input int exp_cyc);
    if (q_done.size() == 1) chk(tag, q_done[0], exp_cyc);
    else chk({tag, "_count"}, q_done.size(), 1);
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_cmd_wr", {31'd0, cmd_wr}, 32'd0);
    chk("rst_cmd_out", {16'h0000, cmd_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset_n = 1'b1;
    repeat (2) step();

    // S1: three data words then control word from a cleared shadow
    stage(7'd0, 16'h2005); stage(7'd1, 16'h4007); stage(7'd2, 16'h6123);
    commit(8'd3);
    chk("s1_busy_rise", {31'd0, busy}, 32'd1);
    chk("s1_no_err", {31'd0, err}, 32'd0);
    vblank = 1'b1;
    capture(12, 1'b0);
    chk("s1_nslots", q_word.size(), 4);
    chk_slot("s1_w0", 0, 4, 16'h2005);
    chk_slot("s1_w1", 1, 5, 16'h4007);
    chk_slot("s1_w2", 2, 6, 16'h6123);
    chk_slot("s1_ctl", 3, 7, 16'h0000);
    chk_done("s1_done", 8);
    for (int i = 0; i < 8; i++) chk("s1_busy_hi", {31'd0, busy_log[i]}, 32'd1);
    chk("s1_busy_fall", {31'd0, busy_log[8]}, 32'd0);

    // S2: embedded control word leaves a bubble and loads the shadow
    vb_low();
    stage(7'd0, 16'h2003); stage(7'd1, 16'h0005); stage(7'd2, 16'h4006);
    commit(8'd3);
    vblank = 1'b1;
    capture(12, 1'b0);
    chk("s2_nslots", q_word.size(), 3);
    chk_slot("s2_w0", 0, 4, 16'h2003);
    chk_slot("s2_w2", 1, 6, 16'h4006);
    chk_slot("s2_ctl", 2, 7, 16'h0005);
    chk_done("s2_done", 8);

    // S3: force_off edges in IDLE give standalone control words, no done
    force_off = 1'b1;
    capture(6, 1'b0);
    chk("s3_on_n", q_word.size(), 1);
    chk_slot("s3_on", 0, 1, 16'h0004);
    chk("s3_on_nodone", q_done.size(), 0);
    force_off = 1'b0;
    capture(6, 1'b0);
    chk("s3_off_n", q_word.size(), 1);
    chk_slot("s3_off", 0, 1, 16'h0005);
    chk("s3_off_nodone", q_done.size(), 0);

    // S4a: out-of-range lengths rejected
    vb_low();
    commit(8'd0);
    chk("s4_len0_err", {31'd0, err}, 32'd1);
    chk("s4_len0_busy", {31'd0, busy}, 32'd0);
    step();
    chk("s4_err_pulse", {31'd0, err}, 32'd0);
    commit(8'd129);
    chk("s4_len129_err", {31'd0, err}, 32'd1);
    chk("s4_len129_busy", {31'd0, busy}, 32'd0);

    // S4b: commit while waiting for vblank is rejected, sequence unchanged
    step();
    commit(8'd3);
    chk("s4b_busy", {31'd0, busy}, 32'd1);
    commit(8'd2);
    chk("s4b_err", {31'd0, err}, 32'd1);
    vblank = 1'b1;
    capture(12, 1'b0);
    chk("s4b_nslots", q_word.size(), 3);
    chk_slot("s4b_w0", 0, 4, 16'h2003);
    chk_slot("s4b_w2", 1, 6, 16'h4006);
    chk_slot("s4b_ctl", 2, 7, 16'h0005);
    chk_done("s4b_done", 8);

    // S4c: staging write while busy is dropped
    vb_low();
    commit(8'd3);
    stage(7'd0, 16'h2AAA);
    chk("s4c_err", {31'd0, err}, 32'd1);
    vblank = 1'b1;
    capture(12, 1'b0);
    chk_slot("s4c_w0", 0, 4, 16'h2003);
    chk_done("s4c_done", 8);

    // S5: full-depth burst on the immediate-start instance
    vb_low();
    for (int k = 0; k < 128; k++) stage(7'(k), 16'h2000 | 16'(k));
    commit_req0 = 1'b1; commit_len = 8'd128;
    step();
    commit_req0 = 1'b0;
    chk("s5_busy", {31'd0, busy0}, 32'd1);
    capture(140, 1'b1);
    chk("s5_nslots", q_word.size(), 129);
    for (int k = 0; k < 128; k++) chk_slot("s5_slot", k, k + 1, 16'h2000 | 16'(k));
    chk_slot("s5_ctl", 128, 129, 16'h0000);
    chk_done("s5_done", 130);

    // S6: reset in the middle of a 20-word burst
    for (int k = 0; k < 20; k++) stage(7'(k), 16'h4000 | 16'(k));
    commit(8'd20);
    vblank = 1'b1;
    capture(15, 1'b0);
    chk("s6_pre_n", q_word.size(), 11);
    chk("s6_word10", {16'h0000, cmd_out}, 32'h0000_400A);
    reset_n = 1'b0;
    #1;
    chk("s6_rst_cmd_wr", {31'd0, cmd_wr}, 32'd0);
    chk("s6_rst_busy", {31'd0, busy}, 32'd0);
    chk("s6_rst_cmd_out", {16'h0000, cmd_out}, 32'd0);
    capture(3, 1'b0);
    chk("s6_rst_quiet", q_word.size(), 0);
    vblank = 1'b0;
    reset_n = 1'b1;
    capture(6, 1'b0);
    chk("s6_post_quiet", q_word.size(), 0);
    commit(8'd20);
    vblank = 1'b1;
    capture(30, 1'b0);
    chk("s6_nslots", q_word.size(), 21);
    chk_slot("s6_first", 0, 4, 16'h4000);
    chk_slot("s6_last", 19, 23, 16'h4013);
    chk_slot("s6_ctl", 20, 24, 16'h0000);
    chk_done("s6_done", 25);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
